// File: rtl/uart_regs_pkg.sv
// uart_regs_pkg: shared register map for the multi-channel UART register block.
//   - per-channel word offsets (CR/SR/TDR/RDR), global IER/ISR addresses
//   - CR reset default and the self-clearing CR bit positions
//   - chan_addr(): word address of a channel register
package uart_regs_pkg;

    typedef enum logic [1:0] {
        REG_CR  = 2'd0,
        REG_SR  = 2'd1,
        REG_TDR = 2'd2,
        REG_RDR = 2'd3
    } reg_off_e;

    localparam int unsigned CH_STRIDE  = 4;
    localparam int unsigned IER_ADDR   = 32'h40;
    localparam int unsigned ISR_ADDR   = 32'h41;
    localparam int unsigned MAX_NCH    = 16;

    localparam logic [31:0] CR_RST_DEF = 32'h0000_C000;

    // Self-clearing FIFO reset commands in CR.
    localparam int unsigned CR_TX_RESET = 4;
    localparam int unsigned CR_RX_RESET = 5;
    localparam logic [31:0] CR_SELF_CLR = (32'd1 << CR_TX_RESET) | (32'd1 << CR_RX_RESET);

    function automatic int unsigned chan_addr(input int unsigned ch, input reg_off_e off);
        return CH_STRIDE * ch + 32'(off);
    endfunction

endpackage

// File: rtl/uart_regs_nch_if.sv
// uart_regs_nch_if: word-addressed register bus.
//   addr/we/re/write_data : requester -> register block, one transfer per cycle
//   read_data/rvalid      : register block -> requester, 1-cycle read latency
interface uart_regs_nch_if #(
    parameter int AW = 22
) ();
    logic [AW-1:0] addr;
    logic          we;
    logic          re;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          rvalid;

    modport master (
        output addr, we, re, write_data,
        input  read_data, rvalid
    );

    modport slave (
        input  addr, we, re, write_data,
        output read_data, rvalid
    );
endinterface

// File: rtl/uart_chan_regs.sv
// uart_chan_regs: state for one UART channel.
//   Ports: clk/rst; addr/we/re/write_data from the bus;
//   cr/tdr registered config and tx data; tx_write/rx_read/sr_read
//   combinational access strobes in the request cycle.
module uart_chan_regs
    import uart_regs_pkg::*;
#(
    parameter int          CH     = 0,
    parameter int          AW     = 22,
    parameter logic [31:0] CR_RST = CR_RST_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic          re,
    input  logic [31:0]   write_data,
    output logic [31:0]   cr,
    output logic [31:0]   tdr,
    output logic          tx_write,
    output logic          rx_read,
    output logic          sr_read
);

    logic        hit_cr, hit_sr, hit_tdr, hit_rdr;
    logic [31:0] cr_d, cr_q;
    logic [31:0] tdr_d, tdr_q;

    assign hit_cr  = (addr == AW'(chan_addr(CH, REG_CR)));
    assign hit_sr  = (addr == AW'(chan_addr(CH, REG_SR)));
    assign hit_tdr = (addr == AW'(chan_addr(CH, REG_TDR)));
    assign hit_rdr = (addr == AW'(chan_addr(CH, REG_RDR)));

    assign tx_write = we & hit_tdr;
    assign rx_read  = re & hit_rdr;
    assign sr_read  = re & hit_sr;

    // Reset-command bits drop one cycle after being seen high; a CPU write
    // in that same cycle replaces the whole word, so it wins bit for bit.
    always_comb begin
        cr_d  = cr_q & ~CR_SELF_CLR;
        tdr_d = tdr_q;
        if (we && hit_cr)  cr_d  = write_data;
        if (we && hit_tdr) tdr_d = write_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cr_q  <= CR_RST;
            tdr_q <= '0;
        end else begin
            cr_q  <= cr_d;
            tdr_q <= tdr_d;
        end
    end

    assign cr  = cr_q;
    assign tdr = tdr_q;

endmodule

// File: rtl/uart_regs_nch.sv
// uart_regs_nch: register block for NCH UART channels.
//   Ports: clk, rst (sync, active-high); bus (slave modport: addr, we, re,
//   write_data, read_data, rvalid); cr/tdr out and sr/rdr in, channel c at
//   bits [32c+31:32c]; tx_write/rx_read/sr_read per-channel strobes;
//   irq_evt per-channel interrupt events; irq = registered |(ISR & IER).
module uart_regs_nch
    import uart_regs_pkg::*;
#(
    parameter int          NCH    = 2,
    parameter int          AW     = 22,
    parameter logic [31:0] CR_RST = CR_RST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    uart_regs_nch_if.slave    bus,
    output logic [NCH*32-1:0] cr,
    output logic [NCH*32-1:0] tdr,
    input  logic [NCH*32-1:0] sr,
    input  logic [NCH*32-1:0] rdr,
    output logic [NCH-1:0]    tx_write,
    output logic [NCH-1:0]    rx_read,
    output logic [NCH-1:0]    sr_read,
    input  logic [NCH-1:0]    irq_evt,
    output logic              irq
);

    logic           hit_ier, hit_isr;
    logic [NCH-1:0] ier_d, ier_q;
    logic [NCH-1:0] isr_d, isr_q, isr_clr;
    logic           irq_d, irq_q;
    logic [31:0]    rdata_d, rdata_q;
    logic           rvalid_d, rvalid_q;

    assign hit_ier = (bus.addr == AW'(IER_ADDR));
    assign hit_isr = (bus.addr == AW'(ISR_ADDR));

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        uart_chan_regs #(
            .CH     (c),
            .AW     (AW),
            .CR_RST (CR_RST)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .addr       (bus.addr),
            .we         (bus.we),
            .re         (bus.re),
            .write_data (bus.write_data),
            .cr         (cr[32*c +: 32]),
            .tdr        (tdr[32*c +: 32]),
            .tx_write   (tx_write[c]),
            .rx_read    (rx_read[c]),
            .sr_read    (sr_read[c])
        );
    end

    // Interrupt state: write-1-to-clear, with a same-cycle event winning.
    always_comb begin
        isr_clr = (bus.we && hit_isr) ? bus.write_data[NCH-1:0] : '0;
        isr_d   = (isr_q & ~isr_clr) | irq_evt;
        ier_d   = (bus.we && hit_ier) ? bus.write_data[NCH-1:0] : ier_q;
        irq_d   = |(isr_q & ier_q);
    end

    // Read mux samples current register state, so a read alongside a write
    // returns the pre-write value; sr/rdr are captured in the request cycle.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = bus.re;
        if (bus.re) begin
            rdata_d = '0;
            if (hit_ier) rdata_d = 32'(ier_q);
            if (hit_isr) rdata_d = 32'(isr_q);
            for (int c = 0; c < NCH; c++) begin
                if (bus.addr == AW'(chan_addr(c, REG_CR)))  rdata_d = cr[32*c +: 32];
                if (bus.addr == AW'(chan_addr(c, REG_SR)))  rdata_d = sr[32*c +: 32];
                if (bus.addr == AW'(chan_addr(c, REG_TDR))) rdata_d = tdr[32*c +: 32];
                if (bus.addr == AW'(chan_addr(c, REG_RDR))) rdata_d = rdr[32*c +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ier_q    <= '0;
            isr_q    <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            ier_q    <= ier_d;
            isr_q    <= isr_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // A read answered in a reset cycle is dropped: the reset wins over the
    // pending response as well as over new requests.
    assign bus.read_data = rdata_q;
    assign bus.rvalid    = rvalid_q & ~rst;
    assign irq           = irq_q;

endmodule

// File: tb/tb_uart_regs_nch.sv
// tb_uart_regs_nch: self-checking bench, NCH=4 build. Read responses are
// checked against a scoreboard of (data, arrival cycle) pushed at issue.
module tb_uart_regs_nch;
    localparam int NCH = 4;
    localparam int AW  = 22;
    localparam logic [31:0] CRR = 32'h0000_C000;
    localparam logic [AW-1:0] A_IER = 22'h40;
    localparam logic [AW-1:0] A_ISR = 22'h41;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rd_exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*32-1:0] cr, tdr, sr, rdr;
    logic [NCH-1:0]    tx_write, rx_read, sr_read, irq_evt;
    logic              irq;
    int                cyc = 0;
    int                n_vec = 0;
    int                n_err = 0;
    rd_exp_t           sb[$];

    uart_regs_nch_if #(.AW(AW)) bus ();

    uart_regs_nch #(.NCH(NCH), .AW(AW), .CR_RST(CRR)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cr       (cr),
        .tdr      (tdr),
        .sr       (sr),
        .rdr      (rdr),
        .tx_write (tx_write),
        .rx_read  (rx_read),
        .sr_read  (sr_read),
        .irq_evt  (irq_evt),
        .irq      (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        bus.addr = a; bus.write_data = d; bus.we = 1'b1;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp);
        bus.addr = a; bus.re = 1'b1;
        sb.push_back('{exp, cyc + 1});
        tick();
        bus.re = 1'b0;
    endtask

    // Response monitor: every rvalid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (bus.rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rd_spurious", bus.rvalid, 1'b0);
            end else begin
                rd_exp_t e;
                e = sb.pop_front();
                chk("rd_data", bus.read_data, e.data);
                chk("rd_lat", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sr = '0; rdr = '0; irq_evt = '0;
        bus.addr = '0; bus.we = 1'b0; bus.re = 1'b0; bus.write_data = '0;
        repeat (2) tick();
        rst = 1'b0;

        // reset defaults
        chk("rst_irq", irq, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_cr", cr, {4{CRR}});
        chk("rst_tdr", tdr, '0);
        for (int c = 0; c < NCH; c++) rd(AW'(4 * c), CRR);
        rd(A_ISR, 32'h0);
        rd(A_IER, 32'h0);

        // self-clear of RX_RESET on CR1, other bits kept
        wr(22'h4, CRR | 32'h20);
        chk("sc_set", cr[63:32], CRR | 32'h20);
        tick();
        chk("sc_clr", cr[63:32], CRR);
        chk("sc_cr0", cr[31:0], CRR);
        // write in the auto-clear cycle wins
        wr(22'h4, 32'h10);
        wr(22'h4, 32'h10);
        chk("sc_wr_wins", cr[63:32], 32'h10);
        tick();
        chk("sc_clr2", cr[63:32], 32'h0);

        // RDR0 read: strobe same cycle, data sampled in the request cycle
        rdr[31:0] = 32'hA5;
        bus.addr = 22'h3; bus.re = 1'b1;
        #1;
        chk("rx_read", rx_read, 4'b0001);
        chk("tx_write_idle", tx_write, 4'b0000);
        sb.push_back('{32'hA5, cyc + 1});
        tick();
        bus.re = 1'b0; rdr[31:0] = 32'h5A;
        // SR1 read strobe
        sr[63:32] = 32'h77;
        bus.addr = 22'h5; bus.re = 1'b1;
        #1;
        chk("sr_read", sr_read, 4'b0010);
        sb.push_back('{32'h77, cyc + 1});
        tick();
        bus.re = 1'b0;
        rd(22'h30, 32'h0);

        // interrupt path
        wr(A_IER, 32'h3);
        irq_evt = 4'b0010;
        tick();
        irq_evt = '0;
        chk("irq_lag", irq, 1'b0);
        tick();
        chk("irq_set", irq, 1'b1);
        rd(A_ISR, 32'h2);
        tick();
        chk("rd_hold", bus.read_data, 32'h2);
        wr(A_ISR, 32'h2);
        tick();
        chk("irq_clr", irq, 1'b0);
        rd(A_ISR, 32'h0);
        bus.addr = A_ISR; bus.write_data = 32'h2; bus.we = 1'b1; irq_evt = 4'b0010;
        tick();
        bus.we = 1'b0; irq_evt = '0;
        rd(A_ISR, 32'h2);
        wr(A_ISR, 32'h0);
        rd(A_ISR, 32'h2);
        wr(A_IER, 32'hFFFF_FFFF);
        rd(A_IER, 32'hF);
        wr(A_IER, 32'h1);
        tick();
        chk("irq_masked", irq, 1'b0);
        wr(A_ISR, 32'hF);

        // TDR3 write
        bus.addr = 22'h0E; bus.write_data = 32'h55; bus.we = 1'b1;
        #1;
        chk("tx_write3", tx_write, 4'b1000);
        tick();
        bus.we = 1'b0;
        chk("tdr3", tdr[127:96], 32'h55);
        chk("tdr_others", tdr[95:0], '0);
        chk("cr_others", cr, {CRR, CRR, 32'h0, CRR});

        // simultaneous write and read of CR0
        bus.addr = 22'h0; bus.write_data = 32'h1; bus.we = 1'b1; bus.re = 1'b1;
        sb.push_back('{CRR, cyc + 1});
        tick();
        bus.we = 1'b0; bus.re = 1'b0;
        rd(22'h0, 32'h1);

        // read just before reset loses its rvalid; reset beats we/irq_evt
        bus.addr = 22'h0; bus.re = 1'b1;
        tick();
        bus.re = 1'b0;
        rst = 1'b1; bus.we = 1'b1; bus.write_data = 32'h1234; irq_evt = 4'hF;
        @(negedge clk);
        chk("rvalid_sup", bus.rvalid, 1'b0);
        tick();
        rst = 1'b0; bus.we = 1'b0; irq_evt = '0;
        chk("rst_cr0", cr[31:0], CRR);
        chk("rst_irq2", irq, 1'b0);
        rd(A_ISR, 32'h0);

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
